// File: rtl/skeeball_pkg.sv
// Shared definitions for the skeeball hole encoder: hole indices, FSM states,
// and the index/one-hot and priority helper functions.
package skeeball_pkg;

   localparam int unsigned NUM_HOLES = 7;

   typedef logic [2:0]           hole_idx_t;
   typedef logic [NUM_HOLES-1:0] hole_vec_t;

   localparam hole_idx_t HOLE_0   = 3'd0;
   localparam hole_idx_t HOLE_10  = 3'd1;
   localparam hole_idx_t HOLE_20  = 3'd2;
   localparam hole_idx_t HOLE_30  = 3'd3;
   localparam hole_idx_t HOLE_40  = 3'd4;
   localparam hole_idx_t HOLE_50  = 3'd5;
   localparam hole_idx_t HOLE_100 = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_QUALIFY,
      ST_EMIT,
      ST_LOCKOUT
   } state_t;

   // Index of a hole to its one-hot points vector.
   function automatic hole_vec_t idx_to_onehot(input hole_idx_t idx);
      hole_vec_t v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Highest set index wins; an all-zero vector returns the gutter index.
   function automatic hole_idx_t priority_idx(input hole_vec_t v);
      hole_idx_t idx;
      idx = HOLE_0;
      for (int unsigned i = 0; i < NUM_HOLES; i++) begin
         if (v[i]) idx = hole_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/skeeball_sync2.sv
// Parameterized-width two-flop synchronizer for asynchronous sensor inputs.
module skeeball_sync2 #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // Two back-to-back flops; only r_sync is safe to use downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/skeeball_hole_encoder.sv
// Skeeball hole encoder: synchronizes and debounces the seven beam-break
// sensors, resolves simultaneous hits by priority, emits a one-cycle one-hot
// points pulse per ball, then locks out until the sensors stay clear.
// Optional feature: define SKEEBALL_HIT_COUNT_EN to add the hit_count output.
module skeeball_hole_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned LOCKOUT_CYCLES  = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       arm,
   input  logic [6:0] raw_hole,
   output logic [6:0] points,
   output logic       hit_valid,
   output logic       busy
`ifdef SKEEBALL_HIT_COUNT_EN
   ,
   output logic [3:0] hit_count
`endif
);

   import skeeball_pkg::*;

   localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES);
   localparam logic [LW-1:0] LCNT_MAX = LW'(LOCKOUT_CYCLES);

   hole_vec_t   w_s;
   hole_idx_t   w_top;
   state_t      r_state,  w_state_nxt;
   hole_idx_t   r_cand,   w_cand_nxt;
   logic [DW-1:0] r_dcnt, w_dcnt_nxt;
   logic [LW-1:0] r_lcnt, w_lcnt_nxt;
   logic [LW-1:0] w_lcnt_inc;
   hole_vec_t   w_points_nxt;
   logic        w_busy_nxt;

   skeeball_sync2 #(
      .WIDTH(NUM_HOLES)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .i_d (raw_hole),
      .o_q (w_s)
   );

   assign w_top      = priority_idx(w_s);
   assign w_lcnt_inc = (r_lcnt == LCNT_MAX) ? LCNT_MAX : r_lcnt + 1'b1;

   // State register plus the candidate and counter datapath.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cand  <= HOLE_0;
         r_dcnt  <= '0;
         r_lcnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cand  <= w_cand_nxt;
         r_dcnt  <= w_dcnt_nxt;
         r_lcnt  <= w_lcnt_nxt;
      end
   end

   // Next-state logic: qualify, upgrade, emit and lockout decisions on w_s.
   always_comb begin
      w_state_nxt = r_state;
      w_cand_nxt  = r_cand;
      w_dcnt_nxt  = r_dcnt;
      w_lcnt_nxt  = r_lcnt;
      unique case (r_state)
         ST_IDLE: begin
            if (arm && (|w_s)) begin
               w_state_nxt = ST_QUALIFY;
               w_cand_nxt  = w_top;
               w_dcnt_nxt  = DW'(1);
            end
         end
         ST_QUALIFY: begin
            if (!arm || !w_s[r_cand]) begin
               w_state_nxt = ST_IDLE;
            end else if (w_top > r_cand) begin
               w_cand_nxt = w_top;
               w_dcnt_nxt = DW'(1);
            end else if (r_dcnt == DCNT_MAX) begin
               w_state_nxt = ST_EMIT;
            end else begin
               w_dcnt_nxt = r_dcnt + 1'b1;
            end
         end
         ST_EMIT: begin
            w_state_nxt = ST_LOCKOUT;
            w_lcnt_nxt  = '0;
         end
         ST_LOCKOUT: begin
            if (|w_s) begin
               w_lcnt_nxt = '0;
            end else begin
               w_lcnt_nxt = w_lcnt_inc;
               if (w_lcnt_inc == LCNT_MAX) w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Output decode from the upcoming state so the outputs can be registered
   // yet still line up with the state they describe.
   always_comb begin
      w_points_nxt = '0;
      if (w_state_nxt == ST_EMIT) w_points_nxt = idx_to_onehot(w_cand_nxt);
      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         points    <= '0;
         hit_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         points    <= w_points_nxt;
         hit_valid <= |w_points_nxt;
         busy      <= w_busy_nxt;
      end
   end

`ifdef SKEEBALL_HIT_COUNT_EN
   logic [3:0] r_hit_count;

   // Saturating per-game hit counter, cleared while idle and disarmed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_count <= '0;
      end else if (r_state == ST_IDLE && !arm) begin
         r_hit_count <= '0;
      end else if (r_state == ST_EMIT && r_hit_count != 4'd9) begin
         r_hit_count <= r_hit_count + 1'b1;
      end
   end

   assign hit_count = r_hit_count;
`endif

endmodule
